// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants and sequencer state encoding shared by alu_arbiter and Alu
package alu_pkg;
  localparam logic [3:0] ALU_AND             = 4'b0000;
  localparam logic [3:0] ALU_OR              = 4'b0001;
  localparam logic [3:0] ALU_SUM             = 4'b0010;
  localparam logic [3:0] ALU_EQUAL           = 4'b0011;
  localparam logic [3:0] ALU_SHIFT_LEFT      = 4'b0100;
  localparam logic [3:0] ALU_SHIFT_RIGHT     = 4'b0101;
  localparam logic [3:0] ALU_SHIFT_RIGHT_A   = 4'b0111;
  localparam logic [3:0] ALU_XOR             = 4'b1000;
  localparam logic [3:0] ALU_NOR             = 4'b1001;
  localparam logic [3:0] ALU_SUB             = 4'b1010;
  localparam logic [3:0] ALU_GREATER_EQUAL   = 4'b1100;
  localparam logic [3:0] ALU_GREATER_EQUAL_U = 4'b1101;
  localparam logic [3:0] ALU_SLT             = 4'b1110;
  localparam logic [3:0] ALU_SLT_U           = 4'b1111;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;
endpackage

// File: rtl/alu_arbiter_alu.sv
// Alu: combinational ALU; undefined opcodes return 0, shifts use rs2[4:0]
module Alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       ALU_OP_i,
  input  logic [WIDTH-1:0] ALU_RS1_i,
  input  logic [WIDTH-1:0] ALU_RS2_i,
  output logic [WIDTH-1:0] ALU_RD_o,
  output logic             ALU_ZR_o
);
  logic [4:0] w_sh;
  assign w_sh = ALU_RS2_i[4:0];
  always_comb begin
    ALU_RD_o = '0;
    case (ALU_OP_i)
      ALU_AND:             ALU_RD_o = ALU_RS1_i & ALU_RS2_i;
      ALU_OR:              ALU_RD_o = ALU_RS1_i | ALU_RS2_i;
      ALU_SUM:             ALU_RD_o = ALU_RS1_i + ALU_RS2_i;
      ALU_EQUAL:           ALU_RD_o = {{(WIDTH-1){1'b0}}, ALU_RS1_i == ALU_RS2_i};
      ALU_SHIFT_LEFT:      ALU_RD_o = ALU_RS1_i << w_sh;
      ALU_SHIFT_RIGHT:     ALU_RD_o = ALU_RS1_i >> w_sh;
      ALU_SHIFT_RIGHT_A:   ALU_RD_o = $signed(ALU_RS1_i) >>> w_sh;
      ALU_XOR:             ALU_RD_o = ALU_RS1_i ^ ALU_RS2_i;
      ALU_NOR:             ALU_RD_o = ~(ALU_RS1_i | ALU_RS2_i);
      ALU_SUB:             ALU_RD_o = ALU_RS1_i - ALU_RS2_i;
      ALU_GREATER_EQUAL:   ALU_RD_o = {{(WIDTH-1){1'b0}}, $signed(ALU_RS1_i) >= $signed(ALU_RS2_i)};
      ALU_GREATER_EQUAL_U: ALU_RD_o = {{(WIDTH-1){1'b0}}, ALU_RS1_i >= ALU_RS2_i};
      ALU_SLT:             ALU_RD_o = {{(WIDTH-1){1'b0}}, $signed(ALU_RS1_i) < $signed(ALU_RS2_i)};
      ALU_SLT_U:           ALU_RD_o = {{(WIDTH-1){1'b0}}, ALU_RS1_i < ALU_RS2_i};
      default:             ALU_RD_o = '0;
    endcase
  end
  assign ALU_ZR_o = ALU_RD_o == '0;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one Alu via IDLE/EXEC/RESP sequencing.
// ALU_ARB_RR_EN selects round-robin contention; otherwise requester 0 has fixed priority.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [4*NUM_REQ-1:0]          req_op_i,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_rs1_i,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_rs2_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  input  logic [NUM_REQ-1:0]            rsp_ready_i,
  output logic [DATA_WIDTH-1:0]         rsp_rd_o,
  output logic                          rsp_zr_o,
  output logic                          busy_o
);
  arb_state_e r_state, w_next;
  logic                  r_gnt;
  logic [3:0]            r_op;
  logic [DATA_WIDTH-1:0] r_rs1, r_rs2, r_rd;
  logic                  r_zr;
  logic                  w_any, w_gnt, w_accept, w_hs, w_alu_zr;
  logic [DATA_WIDTH-1:0] w_alu_rd;
  assign w_any    = |req_valid_i;
  assign w_accept = r_state == IDLE && w_any;
  assign w_hs     = r_state == RESP && rsp_ready_i[r_gnt];
`ifdef ALU_ARB_RR_EN
  logic r_last;
  // last starts at 1 so requester 0 wins the first contention
  assign w_gnt = &req_valid_i ? ~r_last : req_valid_i[1];
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_last <= 1'b1;
    else if (w_hs) r_last <= r_gnt;
  end
`else
  assign w_gnt = ~req_valid_i[0];
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_any ? EXEC : IDLE;
      EXEC:    w_next = RESP;
      RESP:    w_next = w_hs ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_gnt <= 1'b0;
      r_op  <= '0;
      r_rs1 <= '0;
      r_rs2 <= '0;
      r_rd  <= '0;
      r_zr  <= 1'b0;
    end else if (w_accept) begin
      r_gnt <= w_gnt;
      r_op  <= w_gnt ? req_op_i[7:4] : req_op_i[3:0];
      r_rs1 <= w_gnt ? req_rs1_i[DATA_WIDTH +: DATA_WIDTH] : req_rs1_i[DATA_WIDTH-1:0];
      r_rs2 <= w_gnt ? req_rs2_i[DATA_WIDTH +: DATA_WIDTH] : req_rs2_i[DATA_WIDTH-1:0];
    end else if (r_state == EXEC) begin
      r_rd <= w_alu_rd;
      r_zr <= w_alu_zr;
    end
  end
  Alu #(.WIDTH(DATA_WIDTH)) u_alu (
    .ALU_OP_i (r_op),
    .ALU_RS1_i(r_rs1),
    .ALU_RS2_i(r_rs2),
    .ALU_RD_o (w_alu_rd),
    .ALU_ZR_o (w_alu_zr)
  );
  assign req_ready_o = w_accept ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid_o = r_state == RESP ? (r_gnt ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_rd_o    = r_rd;
  assign rsp_zr_o    = r_zr;
  assign busy_o      = r_state != IDLE;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter; expected grants follow ALU_ARB_RR_EN
module tb_alu_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [1:0]  req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
  logic [7:0]  req_op_i;
  logic [63:0] req_rs1_i, req_rs2_i;
  logic [31:0] rsp_rd_o;
  logic        rsp_zr_o, busy_o;
  typedef struct packed {logic g; logic [31:0] rd; logic zr;} exp_t;
  exp_t sb[$];
  exp_t e;
  int n_chk = 0, n_pass = 0;
  alu_arbiter dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i), .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i), .rsp_rd_o(rsp_rd_o), .rsp_zr_o(rsp_zr_o), .busy_o(busy_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic set_req(input int n, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (n == 0) begin
      req_op_i[3:0] = op; req_rs1_i[31:0] = a; req_rs2_i[31:0] = b; req_valid_i[0] = 1'b1;
    end else begin
      req_op_i[7:4] = op; req_rs1_i[63:32] = a; req_rs2_i[63:32] = b; req_valid_i[1] = 1'b1;
    end
  endtask
  task automatic wait_rsp(output logic [1:0] v);
    v = 2'b00;
    for (int i = 0; i < 20 && v == 2'b00; i++) begin
      @(negedge clk_i);
      v = rsp_valid_o;
    end
  endtask
  task automatic test_reset;
    n_chk++; if ({rsp_valid_o, rsp_rd_o, rsp_zr_o, busy_o} !== 36'd0) $display("FAIL reset_outs: got %h want 0", {rsp_valid_o, rsp_rd_o, rsp_zr_o, busy_o}); else n_pass++;
    @(negedge clk_i); rst_n_i = 1'b1; #1;
    n_chk++; if (req_ready_o !== 2'b00) $display("FAIL reset_ready: got %b want 00", req_ready_o); else n_pass++;
  endtask
  task automatic test_contention;
    logic [1:0] v;
    rsp_ready_i = 2'b11;
    set_req(0, 4'b0010, 32'd1, 32'd2);
    set_req(1, 4'b1010, 32'd3, 32'd3);
    sb.push_back('{1'b0, 32'd3, 1'b0});
    sb.push_back('{1'b1, 32'd0, 1'b1});
    #1;
    n_chk++; if (req_ready_o !== 2'b01) $display("FAIL cont_ready0: got %b want 01", req_ready_o); else n_pass++;
    @(negedge clk_i); req_valid_i[0] = 1'b0;
    wait_rsp(v); e = sb.pop_front();
    n_chk++; if (v !== 2'b01) $display("FAIL cont_gnt0: got %b want 01", v); else n_pass++;
    n_chk++; if ({rsp_rd_o, rsp_zr_o} !== {e.rd, e.zr}) $display("FAIL cont_rd0: got %h/%b want %h/%b", rsp_rd_o, rsp_zr_o, e.rd, e.zr); else n_pass++;
    @(negedge clk_i);
    n_chk++; if (req_ready_o !== 2'b10) $display("FAIL cont_ready1: got %b want 10", req_ready_o); else n_pass++;
    @(negedge clk_i); req_valid_i[1] = 1'b0;
    wait_rsp(v); e = sb.pop_front();
    n_chk++; if (v !== 2'b10) $display("FAIL cont_gnt1: got %b want 10", v); else n_pass++;
    n_chk++; if ({rsp_rd_o, rsp_zr_o} !== {e.rd, e.zr}) $display("FAIL cont_rd1: got %h/%b want %h/%b", rsp_rd_o, rsp_zr_o, e.rd, e.zr); else n_pass++;
    @(negedge clk_i);
  endtask
  task automatic test_stream;
    logic [1:0] v;
    logic g;
    set_req(0, 4'b0000, 32'h0000_F0F0, 32'h0000_FF00);
    set_req(1, 4'b1111, 32'd1, 32'd2);
    for (int k = 0; k < 6; k++) begin
`ifdef ALU_ARB_RR_EN
      g = k[0];
`else
      g = 1'b0;
`endif
      sb.push_back('{g, g ? 32'd1 : 32'h0000_F000, 1'b0});
      wait_rsp(v); e = sb.pop_front();
      n_chk++; if (v !== (e.g ? 2'b10 : 2'b01)) $display("FAIL stream_gnt%0d: got %b want %b", k, v, e.g ? 2'b10 : 2'b01); else n_pass++;
      n_chk++; if (rsp_rd_o !== e.rd) $display("FAIL stream_rd%0d: got %h want %h", k, rsp_rd_o, e.rd); else n_pass++;
    end
    req_valid_i = 2'b00;
    @(negedge clk_i);
  endtask
  task automatic test_sum;
    set_req(0, 4'b0010, 32'd5, 32'd7);
    sb.push_back('{1'b0, 32'd12, 1'b0});
    #1;
    n_chk++; if (req_ready_o !== 2'b01) $display("FAIL sum_ready: got %b want 01", req_ready_o); else n_pass++;
    @(negedge clk_i); req_valid_i[0] = 1'b0;
    n_chk++; if ({busy_o, rsp_valid_o} !== 3'b100) $display("FAIL sum_exec: got %b want 100", {busy_o, rsp_valid_o}); else n_pass++;
    @(negedge clk_i); e = sb.pop_front();
    n_chk++; if (rsp_valid_o !== 2'b01) $display("FAIL sum_valid: got %b want 01", rsp_valid_o); else n_pass++;
    n_chk++; if ({rsp_rd_o, rsp_zr_o} !== {e.rd, e.zr}) $display("FAIL sum_rd: got %h/%b want %h/%b", rsp_rd_o, rsp_zr_o, e.rd, e.zr); else n_pass++;
    @(negedge clk_i);
    n_chk++; if ({busy_o, rsp_valid_o} !== 3'b000) $display("FAIL sum_done: got %b want 000", {busy_o, rsp_valid_o}); else n_pass++;
  endtask
  task automatic test_undef;
    logic [1:0] v;
    set_req(0, 4'b0110, 32'd5, 32'd5);
    sb.push_back('{1'b0, 32'd0, 1'b1});
    @(negedge clk_i); req_valid_i[0] = 1'b0;
    wait_rsp(v); e = sb.pop_front();
    n_chk++; if ({v, rsp_rd_o, rsp_zr_o} !== {2'b01, e.rd, e.zr}) $display("FAIL undef: got %b/%h/%b want 01/%h/%b", v, rsp_rd_o, rsp_zr_o, e.rd, e.zr); else n_pass++;
    @(negedge clk_i);
  endtask
  task automatic test_sra;
    logic [1:0] v;
    set_req(1, 4'b0111, 32'h8000_0000, 32'h24);
    sb.push_back('{1'b1, 32'hF800_0000, 1'b0});
    @(negedge clk_i); req_valid_i[1] = 1'b0;
    wait_rsp(v); e = sb.pop_front();
    n_chk++; if ({v, rsp_rd_o, rsp_zr_o} !== {2'b10, e.rd, e.zr}) $display("FAIL sra: got %b/%h/%b want 10/%h/%b", v, rsp_rd_o, rsp_zr_o, e.rd, e.zr); else n_pass++;
    @(negedge clk_i);
  endtask
  task automatic test_backpressure;
    logic [1:0] v;
    rsp_ready_i = 2'b00;
    set_req(1, 4'b1000, 32'hFF, 32'h0F);
    sb.push_back('{1'b1, 32'hF0, 1'b0});
    @(negedge clk_i); req_valid_i[1] = 1'b0;
    set_req(0, 4'b0010, 32'd20, 32'd22);
    sb.push_back('{1'b0, 32'd42, 1'b0});
    wait_rsp(v); e = sb.pop_front();
    n_chk++; if ({v, rsp_rd_o} !== {2'b10, e.rd}) $display("FAIL bp_first: got %b/%h want 10/%h", v, rsp_rd_o, e.rd); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      n_chk++; if ({rsp_valid_o, rsp_rd_o, req_ready_o} !== {2'b10, e.rd, 2'b00}) $display("FAIL bp_hold%0d: got %b/%h/%b want 10/%h/00", i, rsp_valid_o, rsp_rd_o, req_ready_o, e.rd); else n_pass++;
    end
    rsp_ready_i = 2'b11;
    @(negedge clk_i);
    n_chk++; if (req_ready_o !== 2'b01) $display("FAIL bp_release: got %b want 01", req_ready_o); else n_pass++;
    @(negedge clk_i); req_valid_i[0] = 1'b0;
    wait_rsp(v); e = sb.pop_front();
    n_chk++; if ({v, rsp_rd_o} !== {2'b01, e.rd}) $display("FAIL bp_second: got %b/%h want 01/%h", v, rsp_rd_o, e.rd); else n_pass++;
    @(negedge clk_i);
  endtask
  task automatic test_reset_mid;
    logic [1:0] v;
    logic seen;
    set_req(0, 4'b0010, 32'd1, 32'd1);
    @(negedge clk_i); req_valid_i[0] = 1'b0;
    n_chk++; if (busy_o !== 1'b1) $display("FAIL rm_exec: got %b want 1", busy_o); else n_pass++;
    #2 rst_n_i = 1'b0; #1;
    n_chk++; if ({rsp_valid_o, rsp_rd_o, rsp_zr_o, busy_o, req_ready_o} !== 38'd0) $display("FAIL rm_async: got %h want 0", {rsp_valid_o, rsp_rd_o, rsp_zr_o, busy_o, req_ready_o}); else n_pass++;
    @(negedge clk_i); rst_n_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      seen |= |rsp_valid_o;
    end
    n_chk++; if (seen !== 1'b0) $display("FAIL rm_no_rsp: got %b want 0", seen); else n_pass++;
    set_req(0, 4'b1010, 32'd10, 32'd4);
    sb.push_back('{1'b0, 32'd6, 1'b0});
    #1;
    n_chk++; if (req_ready_o !== 2'b01) $display("FAIL rm_accept: got %b want 01", req_ready_o); else n_pass++;
    @(negedge clk_i); req_valid_i[0] = 1'b0;
    wait_rsp(v); e = sb.pop_front();
    n_chk++; if ({v, rsp_rd_o, rsp_zr_o} !== {2'b01, e.rd, e.zr}) $display("FAIL rm_rsp: got %b/%h/%b want 01/%h/%b", v, rsp_rd_o, rsp_zr_o, e.rd, e.zr); else n_pass++;
    @(negedge clk_i);
  endtask
  initial begin
    rst_n_i = 1'b0;
    req_valid_i = 2'b00; rsp_ready_i = 2'b11;
    req_op_i = '0; req_rs1_i = '0; req_rs2_i = '0;
    @(negedge clk_i);
    test_reset;
    test_contention;
    test_stream;
    test_sum;
    test_undef;
    test_sra;
    test_backpressure;
    test_reset_mid;
    n_chk++; if (sb.size() !== 0) $display("FAIL sb_empty: got %0d want 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
